antidiff_cascade: RTL

//  Runtime-selectable-order anti-difference (cascaded running-sum) operator for
//  the USF recovery datapath: inverts an N-th order finite difference on one sample

---
 rtl/usf_pkg.sv | 44 ++++
 rtl/antidiff_stage.sv | 35 +++
 rtl/antidiff_cascade.sv | 120 ++++++++++++
 3 files changed

// File: rtl/usf_pkg.sv
// Shared types and arithmetic for the USF recovery datapath accumulators.
// sat_add works on 64-bit sign-extended operands so any accumulator width up to 63 bits can use it.
package usf_pkg;

    typedef enum logic {
        AD_WRAP = 1'b0,
        AD_SAT  = 1'b1
    } ad_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PROP,
        ST_HOLD
    } ad_state_e;

    localparam int SA_W = 64;
    typedef logic signed [SA_W-1:0] sa_word_t;
    localparam logic signed [SA_W:0] SA_ONE = 1;

    // Returns {ovf, sum}. Callers keep the low w bits of sum.
    // In wrap mode those low bits are the modular result.
    function automatic logic [SA_W:0] sat_add(input sa_word_t a, input sa_word_t b,
                                              input ad_mode_e mode, input int w);
        logic signed [SA_W:0] sum;
        logic signed [SA_W:0] hi;
        logic signed [SA_W:0] lo;
        logic hit;
        sum = {a[SA_W-1], a} + {b[SA_W-1], b};
        hi  = (SA_ONE <<< (w - 1)) - SA_ONE;
        lo  = -(SA_ONE <<< (w - 1));
        hit = 1'b0;
        if (mode == AD_SAT) begin
            if (sum > hi) begin
                sum = hi;
                hit = 1'b1;
            end else if (sum < lo) begin
                sum = lo;
                hit = 1'b1;
            end
        end
        return {hit, sum[SA_W-1:0]};
    endfunction

endpackage

// File: rtl/antidiff_stage.sv
// One running-sum stage: q <= f(q + addend) when enabled.
// ovf_o is sticky and only set by a saturating add.
module antidiff_stage
    import usf_pkg::*;
#(
    parameter int       W    = 16,
    parameter ad_mode_e MODE = AD_WRAP
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] addend,
    output logic [W-1:0] q,
    output logic         ovf_o
);

    sa_word_t q_ext;
    sa_word_t addend_ext;

    assign q_ext      = {{(SA_W - W){q[W-1]}}, q};
    assign addend_ext = {{(SA_W - W){addend[W-1]}}, addend};

    // NOTE: sequential state uses non-blocking assignments; reset and clear override en.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            q     <= '0;
            ovf_o <= 1'b0;
        end else if (en) begin
            q     <= W'(sat_add(q_ext, addend_ext, MODE, W));
            ovf_o <= ovf_o | 1'(sat_add(q_ext, addend_ext, MODE, W) >> SA_W);
        end
    end

endmodule

// File: rtl/antidiff_cascade.sv
// Runtime-order anti-difference operator: up to MAX_ORDER cascaded running sums.
// One stage is written per cycle, and the result is held until downstream takes it.
module antidiff_cascade
    import usf_pkg::*;
#(
    parameter int       W         = 16,
    parameter int       MAX_ORDER = 4,
    parameter ad_mode_e MODE      = AD_WRAP,
    localparam int      OW        = $clog2(MAX_ORDER + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic [OW-1:0] order_i,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          ovf
);

    ad_state_e              state;
    logic [OW-1:0]          order_q;
    logic [OW-1:0]          order_eff;
    logic [OW-1:0]          k;
    logic                   accept;
    logic [MAX_ORDER-1:0]   stage_en;
    logic [MAX_ORDER-1:0]   stage_ovf;
    logic [W-1:0]           stage_q [MAX_ORDER];
    logic [W-1:0]           addend  [MAX_ORDER];

    assign in_ready = !clear && (state == ST_IDLE || (state == ST_HOLD && out_ready));
    assign accept   = in_valid && in_ready;
    assign ovf      = |stage_ovf;

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        order_eff = order_i;
        if (order_i == '0) begin
            order_eff = OW'(1);
        end else if (order_i > OW'(MAX_ORDER)) begin
            order_eff = OW'(MAX_ORDER);
        end
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < MAX_ORDER; i++) begin
            if (order_q == OW'(i + 1)) begin
                out_data = stage_q[i];
            end
        end
    end

    for (genvar i = 0; i < MAX_ORDER; i++) begin : g_stage
        if (i == 0) begin : g_first
            assign stage_en[i] = accept;
            assign addend[i]   = in_data;
        end else begin : g_next
            assign stage_en[i] = (state == ST_PROP) && (k == OW'(i));
            assign addend[i]   = stage_q[i-1];
        end

        antidiff_stage #(
            .W    (W),
            .MODE (MODE)
        ) u_stage (
            .clk    (clk),
            .reset  (reset),
            .clear  (clear),
            .en     (stage_en[i]),
            .addend (addend[i]),
            .q      (stage_q[i]),
            .ovf_o  (stage_ovf[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state     <= ST_IDLE;
            order_q   <= OW'(1);
            k         <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_HOLD: begin
                    if (accept) begin
                        order_q <= order_eff;
                        if (order_eff == OW'(1)) begin
                            state     <= ST_HOLD;
                            out_valid <= 1'b1;
                        end else begin
                            state     <= ST_PROP;
                            k         <= OW'(1);
                            out_valid <= 1'b0;
                        end
                    end else if (state == ST_HOLD && out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                ST_PROP: begin
                    if (k == order_q - OW'(1)) begin
                        state     <= ST_HOLD;
                        out_valid <= 1'b1;
                    end else begin
                        k <= k + OW'(1);
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
